// File: rtl/trig_capture_pkg.sv
// Shared types for the trigger capture controller.
// State encoding and trigger-enable bit positions.
package trig_capture_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    POST = 2'd2,
    DONE = 2'd3
  } cap_state_t;

  localparam int TRIG_SPI  = 0;
  localparam int TRIG_UART = 1;

endpackage

// File: rtl/cap_addr_cnt.sv
// Wrapping sample RAM write address plus a saturating
// pre-trigger fill counter that flags when the window is full.
module cap_addr_cnt #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              wr,
  input  logic              fill_en,
  input  logic [ADDR_W:0]   limit,
  output logic [ADDR_W-1:0] waddr,
  output logic              full
);

  localparam logic [ADDR_W-1:0] A_ONE = 1;
  localparam logic [ADDR_W:0]   C_ONE = 1;

  logic [ADDR_W:0] fill;
  logic [ADDR_W:0] fill_nxt;

  assign fill_nxt = fill + C_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waddr <= '0;
      fill  <= '0;
      full  <= 1'b0;
    end else if (clr) begin
      waddr <= '0;
      fill  <= '0;
      full  <= 1'b0;
    end else if (wr) begin
      waddr <= waddr + A_ONE;
      // fill stops counting once it reaches the limit
      if (fill_en && !full) begin
        fill <= fill_nxt;
        full <= (fill_nxt == limit);
      end
    end
  end

endmodule

// File: rtl/trig_capture.sv
// Capture controller: qualifies protocol triggers, drives the
// circular sample RAM write side and counts post-trigger samples.
module trig_capture
  import trig_capture_pkg::*;
#(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              clr_done,
  input  logic              smpl_en,
  input  logic              SPItrig,
  input  logic              UARTtrig,
  input  logic              trig_force,
  input  logic [1:0]        trig_en,
  input  logic [ADDR_W-1:0] trig_pos,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              armed,
  output logic              triggered,
  output logic              capt_done
);

  localparam logic [ADDR_W:0] DEPTH_V = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] C_ONE   = 1;

  cap_state_t      state;
  logic            trig_raw;
  logic            trig_q;
  logic            start;
  logic            capturing;
  logic            accept;
  logic [ADDR_W:0] limit;
  logic [ADDR_W:0] post_cnt;
  logic [ADDR_W:0] post_nxt;
  logic [ADDR_W:0] pos_ext;

  assign trig_raw = (trig_en[TRIG_SPI] & SPItrig)
                  | (trig_en[TRIG_UART] & UARTtrig)
                  | trig_force;

  assign pos_ext   = {1'b0, trig_pos};
  assign limit     = DEPTH_V - pos_ext;
  assign post_nxt  = post_cnt + C_ONE;
  assign capturing = (state == PRE) || (state == POST);
  assign we        = capturing & smpl_en;
  assign start     = run && ((state == IDLE) || (state == DONE));
  assign accept    = (state == PRE) && armed && trig_q;
  assign capt_done = (state == DONE);

  cap_addr_cnt #(
    .ADDR_W (ADDR_W)
  ) u_addr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (start),
    .wr      (we),
    .fill_en (state == PRE),
    .limit   (limit),
    .waddr   (waddr),
    .full    (armed)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_q <= 1'b0;
    end else begin
      trig_q <= trig_raw;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      trig_addr <= '0;
      triggered <= 1'b0;
      post_cnt  <= '0;
    end else if (start) begin
      state     <= PRE;
      triggered <= 1'b0;
      post_cnt  <= '0;
    end else begin
      unique case (state)
        PRE: begin
          if (accept) begin
            trig_addr <= waddr;
            triggered <= 1'b1;
            state     <= (trig_pos == '0) ? DONE : POST;
          end
        end
        POST: begin
          if (we) begin
            post_cnt <= post_nxt;
            if (post_nxt == pos_ext) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (clr_done) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= state;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trig_capture.sv
// Directed bench for trig_capture at ADDR_W=4 (DEPTH=16).
// Expected values are hand-derived edge by edge.
module tb_trig_capture;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run = 1'b0;
  logic          clr_done = 1'b0;
  logic          smpl_en = 1'b0;
  logic          SPItrig = 1'b0;
  logic          UARTtrig = 1'b0;
  logic          trig_force = 1'b0;
  logic [1:0]    trig_en = 2'b00;
  logic [AW-1:0] trig_pos = '0;
  logic          we;
  logic [AW-1:0] waddr;
  logic [AW-1:0] trig_addr;
  logic          armed;
  logic          triggered;
  logic          capt_done;

  int n_chk = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int bad_we = 0;
  int ph = 0;
  int loops;

  trig_capture #(
    .ADDR_W (AW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .clr_done   (clr_done),
    .smpl_en    (smpl_en),
    .SPItrig    (SPItrig),
    .UARTtrig   (UARTtrig),
    .trig_force (trig_force),
    .trig_en    (trig_en),
    .trig_pos   (trig_pos),
    .we         (we),
    .waddr      (waddr),
    .trig_addr  (trig_addr),
    .armed      (armed),
    .triggered  (triggered),
    .capt_done  (capt_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (we) wr_cnt++;
    if (we && !smpl_en) bad_we++;
  end

  task automatic check(input string tag,
                       input int got,
                       input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_s();
    smpl_en = (ph == 0);
    ph = (ph + 1) % 3;
    tick();
  endtask

  initial begin
    // reset state
    #2;
    check("rst_we", int'(we), 0);
    check("rst_waddr", int'(waddr), 0);
    check("rst_taddr", int'(trig_addr), 0);
    check("rst_armed", int'(armed), 0);
    check("rst_trig", int'(triggered), 0);
    check("rst_done", int'(capt_done), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // SPI trigger after pre-fill, trig_pos=4
    trig_en = 2'b01;
    trig_pos = 4'd4;
    smpl_en = 1'b1;
    check("idle_we", int'(we), 0);
    run = 1'b1;
    tick();
    run = 1'b0;
    wr_cnt = 0;
    repeat (11) tick();
    check("t2_arm11", int'(armed), 0);
    tick();
    check("t2_arm12", int'(armed), 1);
    repeat (7) tick();
    SPItrig = 1'b1;
    tick();
    SPItrig = 1'b0;
    check("t2_trig_lat", int'(triggered), 0);
    tick();
    check("t2_trig", int'(triggered), 1);
    check("t2_taddr", int'(trig_addr), 4);
    check("t2_waddr", int'(waddr), 5);
    wr_cnt = 0;
    repeat (3) tick();
    check("t2_notdone", int'(capt_done), 0);
    tick();
    check("t2_done", int'(capt_done), 1);
    check("t2_wend", int'(waddr), 9);
    check("t2_posts", wr_cnt, 4);
    repeat (2) tick();
    check("t2_nowr", wr_cnt, 4);
    check("t2_sticky", int'(capt_done), 1);

    // clr_done returns to IDLE
    clr_done = 1'b1;
    tick();
    clr_done = 1'b0;
    check("t6_clr", int'(capt_done), 0);
    check("t6_idle_we", int'(we), 0);

    // early SPI ignored, later UART accepted
    run = 1'b1;
    tick();
    run = 1'b0;
    check("t3_w0", int'(waddr), 0);
    repeat (4) tick();
    SPItrig = 1'b1;
    tick();
    SPItrig = 1'b0;
    tick();
    check("t3_early", int'(triggered), 0);
    trig_en = 2'b11;
    repeat (6) tick();
    check("t3_arm", int'(armed), 1);
    run = 1'b1;
    tick();
    run = 1'b0;
    check("t6_run_pre", int'(waddr), 13);
    UARTtrig = 1'b1;
    tick();
    UARTtrig = 1'b0;
    tick();
    check("t3_trig", int'(triggered), 1);
    check("t3_taddr", int'(trig_addr), 14);
    repeat (4) tick();
    check("t3_done", int'(capt_done), 1);
    check("t3_wend", int'(waddr), 3);

    // run+clr_done together, disabled sources, force
    trig_en = 2'b00;
    trig_pos = 4'd0;
    run = 1'b1;
    clr_done = 1'b1;
    tick();
    run = 1'b0;
    clr_done = 1'b0;
    check("t6_rc_done", int'(capt_done), 0);
    check("t6_rc_waddr", int'(waddr), 0);
    check("t6_rc_trig", int'(triggered), 0);
    check("t6_rc_armed", int'(armed), 0);
    repeat (15) tick();
    check("t4_arm15", int'(armed), 0);
    tick();
    check("t4_arm16", int'(armed), 1);
    SPItrig = 1'b1;
    UARTtrig = 1'b1;
    tick();
    SPItrig = 1'b0;
    UARTtrig = 1'b0;
    tick();
    check("t4_dis", int'(triggered), 0);
    trig_force = 1'b1;
    tick();
    trig_force = 1'b0;
    wr_cnt = 0;
    tick();
    check("t4_trig", int'(triggered), 1);
    check("t4_done", int'(capt_done), 1);
    check("t4_taddr", int'(trig_addr), 3);
    check("t4_wr1", wr_cnt, 1);
    tick();
    check("t4_nopost", wr_cnt, 1);

    // sparse strobe, trig_pos=15, address wrap
    trig_en = 2'b01;
    trig_pos = 4'd15;
    smpl_en = 1'b0;
    run = 1'b1;
    tick();
    run = 1'b0;
    ph = 0;
    tick_s();
    check("t5_arm", int'(armed), 1);
    SPItrig = 1'b1;
    tick_s();
    SPItrig = 1'b0;
    tick_s();
    check("t5_trig", int'(triggered), 1);
    check("t5_taddr", int'(trig_addr), 1);
    wr_cnt = 0;
    loops = 0;
    while (!capt_done && loops < 100) begin
      tick_s();
      loops++;
    end
    check("t5_timeout", int'(loops < 100), 1);
    check("t5_posts", wr_cnt, 15);
    check("t5_wrap", int'(waddr), 0);
    check("t5_gated", bad_we, 0);

    // asynchronous reset in POST
    trig_pos = 4'd4;
    smpl_en = 1'b1;
    run = 1'b1;
    tick();
    run = 1'b0;
    repeat (12) tick();
    trig_force = 1'b1;
    tick();
    trig_force = 1'b0;
    repeat (2) tick();
    check("t1_inpost", int'(triggered), 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("t1_we", int'(we), 0);
    check("t1_waddr", int'(waddr), 0);
    check("t1_taddr", int'(trig_addr), 0);
    check("t1_armed", int'(armed), 0);
    check("t1_trig", int'(triggered), 0);
    check("t1_done", int'(capt_done), 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("t1_idle_we", int'(we), 0);
    check("t1_idle_wa", int'(waddr), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
